// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//
// Two-master to one-slave AXI write-channel arbiter with a single write
// transaction outstanding. A winner is latched in IDLE from the sampled
// m<i>_awvalid. Its AW, W and B channels are then routed to and from the
// shared slave port, one phase at a time (ADDR -> DATA -> RESP). After the
// B handshake the block always spends one cycle in IDLE before it can
// grant again.
//
// Configuration macro:
//   AXI_WR_ARB_FIXED_PRIO_EN  defined   : master 0 always wins a tie, and
//                                         there is no round-robin pointer.
//                             undefined : round-robin; a tie goes to the
//                                         master not granted last.
//
// Parameters:
//   ID_W    AXI ID width (all *id ports)
//   ADDR_W  address width
//   DATA_W  data width (strobe width is DATA_W/8)
//
// Ports:
//   aclk, aresetn              clock and asynchronous active-low reset
//   m<i>_aw*                   master i write-address channel (i = 0, 1)
//   m<i>_w*                    master i write-data channel
//   m<i>_b*                    master i write-response channel
//   s_aw*, s_w*, s_bready      shared slave-side request signals (outputs)
//   s_awready, s_wready, s_b*  slave-side ready and response (inputs)
//   grant_id                   current owner; meaningful only while busy=1
//   busy                       high from grant until the B handshake completes
// ---------------------------------------------------------------------------
module axi_wr_arbiter #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  // master 0
  input  logic [ID_W-1:0]       m0_awid,
  input  logic [ADDR_W-1:0]     m0_awaddr,
  input  logic [7:0]            m0_awlen,
  input  logic [2:0]            m0_awsize,
  input  logic [1:0]            m0_awburst,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [ID_W-1:0]       m0_wid,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  input  logic                  m0_wlast,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [ID_W-1:0]       m0_bid,
  output logic [1:0]            m0_bresp,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,

  // master 1
  input  logic [ID_W-1:0]       m1_awid,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [7:0]            m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic [1:0]            m1_awburst,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [ID_W-1:0]       m1_wid,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [ID_W-1:0]       m1_bid,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,

  // slave side
  output logic [ID_W-1:0]       s_awid,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [ID_W-1:0]       s_wid,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wlast,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [ID_W-1:0]       s_bid,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,

  // status
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   req_any;
  logic   winner;

  // Owner-side views of the handshake inputs, selected by the registered grant.
  logic   own_awvalid;
  logic   own_wvalid;
  logic   own_wlast;
  logic   own_bready;

  assign req_any     = m0_awvalid | m1_awvalid;
  assign own_awvalid = grant_q ? m1_awvalid : m0_awvalid;
  assign own_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
  assign own_wlast   = grant_q ? m1_wlast   : m0_wlast;
  assign own_bready  = grant_q ? m1_bready  : m0_bready;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
  assign winner = m0_awvalid ? 1'b0 : 1'b1;
`else
  // Pointer to the master granted most recently. Its reset value of 1 hands
  // the first tie after reset to master 0.
  logic last_q;

  // A tie goes to whichever master was not granted last.
  assign winner = (m0_awvalid && m1_awvalid) ? ~last_q : m1_awvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_q <= 1'b1;
    end else if (state_q == StIdle && req_any) begin
      last_q <= winner;
    end
  end
`endif

  // Grant changes only on a sampled request in IDLE.
  always_comb begin
    grant_d = grant_q;
    if (state_q == StIdle && req_any) begin
      grant_d = winner;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
    end
  end

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_any)                              state_d = StAddr;
      StAddr: if (own_awvalid && s_awready)             state_d = StData;
      StData: if (own_wvalid && s_wready && own_wlast)  state_d = StResp;
      StResp: if (s_bvalid && own_bready)               state_d = StIdle;
      default:                                          state_d = StIdle;
    endcase
  end

  // FSM outputs. Payloads always follow the registered grant. Valids and
  // readies are gated so that each one is live only in its own phase and
  // only toward the owner.
  always_comb begin
    s_awid    = grant_q ? m1_awid    : m0_awid;
    s_awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
    s_awlen   = grant_q ? m1_awlen   : m0_awlen;
    s_awsize  = grant_q ? m1_awsize  : m0_awsize;
    s_awburst = grant_q ? m1_awburst : m0_awburst;
    s_wid     = grant_q ? m1_wid     : m0_wid;
    s_wdata   = grant_q ? m1_wdata   : m0_wdata;
    s_wstrb   = grant_q ? m1_wstrb   : m0_wstrb;
    s_wlast   = grant_q ? m1_wlast   : m0_wlast;

    m0_bid    = s_bid;
    m0_bresp  = s_bresp;
    m1_bid    = s_bid;
    m1_bresp  = s_bresp;

    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StAddr: begin
        s_awvalid = own_awvalid;
        if (grant_q) m1_awready = s_awready;
        else         m0_awready = s_awready;
      end
      StData: begin
        s_wvalid = own_wvalid;
        if (grant_q) m1_wready = s_wready;
        else         m0_wready = s_wready;
      end
      StResp: begin
        s_bready = own_bready;
        if (grant_q) m1_bvalid = s_bvalid;
        else         m0_bvalid = s_bvalid;
      end
      default: ;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule
